// File: rtl/instr_mem_loadable_if.sv
// Fetch and program-load signal bundle for instr_mem_loadable.
// master = fetch stage / boot loader side, slave = the memory.
interface instr_mem_loadable_if #(
  parameter int ADDR_W      = 8,
  parameter int INSTR_WIDTH = 9
);
  logic                   fetch_req;
  logic [ADDR_W-1:0]      fetch_addr;
  logic                   fetch_ready;
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic                   addr_err;
  logic                   parity_err;

  logic                   load_start;
  logic [ADDR_W-1:0]      load_base;
  logic                   load_valid;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   load_last;
  logic                   load_ready;
  logic                   load_done;
  logic                   load_overflow;

  modport master (
    output fetch_req, fetch_addr, load_start, load_base, load_valid, load_data, load_last,
    input  fetch_ready, instr_valid, instr_out, addr_err, parity_err,
           load_ready, load_done, load_overflow
  );

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_base, load_valid, load_data, load_last,
    output fetch_ready, instr_valid, instr_out, addr_err, parity_err,
           load_ready, load_done, load_overflow
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory; optional stored even parity under INSTR_MEM_PARITY_EN.
// Latency: fetch data 1 cycle after acceptance; load_done 1 cycle after the last beat.
// Backpressure: fetch_ready low in LOAD or when load_start is seen; load_ready high only in LOAD.
module instr_mem_loadable #(
  parameter int ROM_SIZE    = 256,
  parameter int INSTR_WIDTH = 9
) (
  input  logic                clk,
  input  logic                reset_n,
  instr_mem_loadable_if.slave bus
);
  localparam int ADDR_W = $clog2(ROM_SIZE);
`ifdef INSTR_MEM_PARITY_EN
  localparam int STORE_W = INSTR_WIDTH + 1;
`else
  localparam int STORE_W = INSTR_WIDTH;
`endif
  localparam logic [ADDR_W:0]   SIZE_X    = (ADDR_W + 1)'(ROM_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_SIZE - 1);

  typedef enum logic {ST_IDLE, ST_LOAD} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic                   load_overflow_q, load_overflow_d;
  logic                   load_done_q, load_done_d;
  logic                   instr_valid_q, instr_valid_d;
  logic [INSTR_WIDTH-1:0] instr_out_q, instr_out_d;
  logic                   addr_err_q, addr_err_d;
  logic                   parity_err_q, parity_err_d;

  // Deliberately unreset so a program survives a core reset.
  logic [STORE_W-1:0] mem [ROM_SIZE];

  logic               fetch_ready, load_ready;
  logic               fetch_acc, mem_we;
  logic               fetch_in_range, wr_in_range;
  logic [ADDR_W-1:0]  rd_idx;
  logic [STORE_W-1:0] rd_word, wr_word;

  assign fetch_in_range = {1'b0, bus.fetch_addr} < SIZE_X;
  assign wr_in_range    = {1'b0, wr_ptr_q} < SIZE_X;
  assign rd_idx         = fetch_in_range ? bus.fetch_addr : '0;
  assign rd_word        = mem[rd_idx];

`ifdef INSTR_MEM_PARITY_EN
  assign wr_word = {^bus.load_data, bus.load_data};
`else
  assign wr_word = bus.load_data;
`endif

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    load_overflow_d = load_overflow_q;
    load_done_d     = 1'b0;
    instr_valid_d   = 1'b0;
    instr_out_d     = instr_out_q;
    addr_err_d      = 1'b0;
    parity_err_d    = 1'b0;
    fetch_ready     = 1'b0;
    load_ready      = 1'b0;
    fetch_acc       = 1'b0;
    mem_we          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // load_start wins over a same-cycle fetch.
        fetch_ready = !bus.load_start;
        fetch_acc   = bus.fetch_req && !bus.load_start;
        if (bus.load_start) begin
          state_d         = ST_LOAD;
          wr_ptr_d        = bus.load_base;
          load_overflow_d = 1'b0;
        end
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (bus.load_valid) begin
          mem_we = wr_in_range;
          if (wr_ptr_q == LAST_ADDR) begin
            wr_ptr_d        = '0;
            load_overflow_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          if (bus.load_last) begin
            state_d     = ST_IDLE;
            load_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fetch_acc) begin
      instr_valid_d = 1'b1;
      if (fetch_in_range) begin
        instr_out_d = rd_word[INSTR_WIDTH-1:0];
`ifdef INSTR_MEM_PARITY_EN
        parity_err_d = ^rd_word;
`endif
      end else begin
        instr_out_d = '0;
        addr_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      wr_ptr_q        <= '0;
      load_overflow_q <= 1'b0;
      load_done_q     <= 1'b0;
      instr_valid_q   <= 1'b0;
      instr_out_q     <= '0;
      addr_err_q      <= 1'b0;
      parity_err_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      load_overflow_q <= load_overflow_d;
      load_done_q     <= load_done_d;
      instr_valid_q   <= instr_valid_d;
      instr_out_q     <= instr_out_d;
      addr_err_q      <= addr_err_d;
      parity_err_q    <= parity_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  assign bus.fetch_ready   = fetch_ready;
  assign bus.load_ready    = load_ready;
  assign bus.instr_valid   = instr_valid_q;
  assign bus.instr_out     = instr_out_q;
  assign bus.addr_err      = addr_err_q;
  assign bus.parity_err    = parity_err_q;
  assign bus.load_done     = load_done_q;
  assign bus.load_overflow = load_overflow_q;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable (ROM_SIZE=164, 9-bit words).
module tb_instr_mem_loadable;
  localparam int ROM_SIZE    = 164;
  localparam int INSTR_WIDTH = 9;
  localparam int ADDR_W      = $clog2(ROM_SIZE);

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [INSTR_WIDTH-1:0] prog [8];

  instr_mem_loadable_if #(.ADDR_W(ADDR_W), .INSTR_WIDTH(INSTR_WIDTH)) bus ();

  instr_mem_loadable #(.ROM_SIZE(ROM_SIZE), .INSTR_WIDTH(INSTR_WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input string tag, input int addr, input logic [INSTR_WIDTH-1:0] exp,
                           input logic exp_err, input logic exp_par);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = ADDR_W'(addr);
    #1 chk({tag, "_frdy"}, 32'(bus.fetch_ready), 32'd1);
    tick();
    bus.fetch_req = 1'b0;
    chk({tag, "_vld"}, 32'(bus.instr_valid), 32'd1);
    chk({tag, "_dat"}, 32'(bus.instr_out), 32'(exp));
    chk({tag, "_aerr"}, 32'(bus.addr_err), 32'(exp_err));
    chk({tag, "_perr"}, 32'(bus.parity_err), 32'(exp_par));
  endtask

  task automatic load_prog(input string tag, input int base, input int n);
    bus.load_start = 1'b1;
    bus.load_base  = ADDR_W'(base);
    #1 chk({tag, "_frdy_start"}, 32'(bus.fetch_ready), 32'd0);
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = prog[i];
      bus.load_last  = (i == n - 1);
      #1 chk({tag, "_lrdy"}, 32'(bus.load_ready), 32'd1);
      chk({tag, "_frdy_load"}, 32'(bus.fetch_ready), 32'd0);
      tick();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk({tag, "_done"}, 32'(bus.load_done), 32'd1);
    tick();
    chk({tag, "_done_pulse"}, 32'(bus.load_done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.load_start = 1'b0;
    bus.load_base  = '0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;

    // Reset values
    #2 reset_n = 1'b0;
    tick();
    chk("rst_vld", 32'(bus.instr_valid), 32'd0);
    chk("rst_dat", 32'(bus.instr_out), 32'd0);
    chk("rst_aerr", 32'(bus.addr_err), 32'd0);
    chk("rst_perr", 32'(bus.parity_err), 32'd0);
    chk("rst_done", 32'(bus.load_done), 32'd0);
    chk("rst_ovf", 32'(bus.load_overflow), 32'd0);
    chk("rst_lrdy", 32'(bus.load_ready), 32'd0);
    chk("rst_frdy", 32'(bus.fetch_ready), 32'd1);
    bus.load_start = 1'b1;
    #1 chk("rst_frdy_ls", 32'(bus.fetch_ready), 32'd0);
    bus.load_start = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Basic load at base 0 and single fetches
    prog[0] = 9'h046; prog[1] = 9'h056; prog[2] = 9'h1D6;
    load_prog("ld0", 0, 3);
    fetch_chk("f0", 0, 9'h046, 1'b0, 1'b0);
    fetch_chk("f1", 1, 9'h056, 1'b0, 1'b0);
    fetch_chk("f2", 2, 9'h1D6, 1'b0, 1'b0);

    // Back-to-back fetches 2, 0, 1
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'd2;
    tick();
    chk("b2b0_vld", 32'(bus.instr_valid), 32'd1);
    chk("b2b0_dat", 32'(bus.instr_out), 32'h1D6);
    bus.fetch_addr = 8'd0;
    tick();
    chk("b2b1_vld", 32'(bus.instr_valid), 32'd1);
    chk("b2b1_dat", 32'(bus.instr_out), 32'h046);
    bus.fetch_addr = 8'd1;
    tick();
    chk("b2b2_vld", 32'(bus.instr_valid), 32'd1);
    chk("b2b2_dat", 32'(bus.instr_out), 32'h056);
    bus.fetch_req = 1'b0;
    tick();
    chk("hold_vld", 32'(bus.instr_valid), 32'd0);
    chk("hold_dat", 32'(bus.instr_out), 32'h056);

    // Wrapping load at the top of the array
    prog[0] = 9'h101; prog[1] = 9'h102; prog[2] = 9'h103; prog[3] = 9'h104;
    load_prog("ldw", 162, 4);
    chk("ldw_ovf", 32'(bus.load_overflow), 32'd1);
    fetch_chk("w162", 162, 9'h101, 1'b0, 1'b0);
    fetch_chk("w163", 163, 9'h102, 1'b0, 1'b0);
    fetch_chk("w0", 0, 9'h103, 1'b0, 1'b0);
    fetch_chk("w1", 1, 9'h104, 1'b0, 1'b0);
    fetch_chk("w2", 2, 9'h1D6, 1'b0, 1'b0);
    fetch_chk("oor200", 200, 9'h000, 1'b1, 1'b0);
    fetch_chk("oor164", 164, 9'h000, 1'b1, 1'b0);
    chk("ovf_sticky", 32'(bus.load_overflow), 32'd1);

    // load_start collides with fetch_req; minimal one-beat load
    bus.load_start = 1'b1; bus.load_base = 8'd10;
    bus.fetch_req  = 1'b1; bus.fetch_addr = 8'd0;
    #1 chk("coll_frdy", 32'(bus.fetch_ready), 32'd0);
    tick();
    bus.load_start = 1'b0; bus.fetch_req = 1'b0;
    chk("coll_vld", 32'(bus.instr_valid), 32'd0);
    chk("coll_lrdy", 32'(bus.load_ready), 32'd1);
    chk("coll_ovf_clr", 32'(bus.load_overflow), 32'd0);
    bus.load_valid = 1'b1; bus.load_data = 9'h0AA; bus.load_last = 1'b1;
    tick();
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    chk("min_done", 32'(bus.load_done), 32'd1);
    fetch_chk("f10", 10, 9'h0AA, 1'b0, 1'b0);

    // Reset in the middle of a load
    bus.load_start = 1'b1; bus.load_base = 8'd162;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1; bus.load_data = 9'h111;
    tick();
    bus.load_data = 9'h122;
    tick();
    bus.load_valid = 1'b0;
    chk("mid_ovf_pre", 32'(bus.load_overflow), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_lrdy", 32'(bus.load_ready), 32'd0);
    chk("mid_ovf", 32'(bus.load_overflow), 32'd0);
    chk("mid_dat", 32'(bus.instr_out), 32'd0);
    chk("mid_frdy", 32'(bus.fetch_ready), 32'd1);
    tick();
    chk("mid_done_rst", 32'(bus.load_done), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("mid_done_after", 32'(bus.load_done), 32'd0);
    fetch_chk("r162", 162, 9'h111, 1'b0, 1'b0);
    fetch_chk("r163", 163, 9'h122, 1'b0, 1'b0);
    chk("mid_lrdy_idle", 32'(bus.load_ready), 32'd0);

`ifdef INSTR_MEM_PARITY_EN
    // Corrupt one stored data bit; data returned as stored, parity flagged
    dut.mem[162][0] = ~dut.mem[162][0];
    fetch_chk("par162", 162, 9'h110, 1'b0, 1'b1);
    fetch_chk("par163", 163, 9'h122, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, synchronous, loadable instruction memory for the emulator core. Replaces a hard-coded combinational program ROM with a clocked array that a testbench or boot controller streams a program into over a valid/ready port. Fetches are registered with one-cycle latency. Sits between the PC/fetch stage and the program-load path.

## Interface

Parameters:
- ROM_SIZE, 256: number of instruction words (any value ≥ 2; need not be a power of two)
- INSTR_WIDTH, 9: bits per instruction
- ADDR_W, $clog2(ROM_SIZE): derived localparam, address width

Ports:
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  word address to fetch
- fetch_ready  out  1  fetch accepted this cycle when high with fetch_req
- instr_valid  out  1  instr_out valid (one-cycle pulse per accepted fetch)
- instr_out  out  INSTR_WIDTH  fetched instruction
- addr_err  out  1  accompanies instr_valid; fetch_addr was ≥ ROM_SIZE
- load_start  in  1  begin program load at load_base
- load_base  in  ADDR_W  first word address of load
- load_valid  in  1  load beat present
- load_data  in  INSTR_WIDTH  load beat payload
- load_last  in  1  marks final beat
- load_ready  out  1  load beat accepted when high with load_valid
- load_done  out  1  one-cycle pulse after last beat is written
- load_overflow  out  1  sticky; write pointer wrapped during current/last load
- parity_err  out  1  accompanies instr_valid; stored parity mismatch (0 unless parity is compiled in)

## Operation

- FSM states: IDLE, LOAD. Reset → IDLE.
- IDLE: fetch_ready = !load_start. load_ready = 0. load_start=1 → LOAD; wr_ptr ← load_base; load_overflow ← 0. load_start has priority over a simultaneous fetch_req (that fetch is not accepted).
- LOAD: fetch_ready = 0; load_ready = 1. Each beat (load_valid & load_ready) writes mem[wr_ptr] ← load_data; wr_ptr ← wr_ptr+1, wrapping ROM_SIZE-1 → 0 and setting load_overflow. Beat with load_last → IDLE, load_done pulses next cycle. load_start in LOAD is ignored.
- Accepted fetch with fetch_addr < ROM_SIZE: next cycle instr_valid=1, instr_out=mem[fetch_addr], addr_err=0.
- Accepted fetch with fetch_addr ≥ ROM_SIZE: next cycle instr_valid=1, instr_out=0, addr_err=1.
- instr_out holds its last value when no fetch is accepted; instr_valid, addr_err, and parity_err are 0.
- The memory array is not reset; contents survive reset_n. Unwritten words read as X in simulation.
- Fetch and write never coincide, so no read-during-write hazard exists.

## Timing

- Reset values: state=IDLE, instr_valid=0, instr_out=0, addr_err=0, parity_err=0, load_done=0, load_overflow=0, wr_ptr=0. fetch_ready reset value = !load_start; load_ready=0.
- Fetch latency: 1 cycle, throughput of one fetch per cycle in IDLE.
- Write latency: the word is readable by a fetch accepted in the cycle after load_done pulses.
- Minimum load: load_start cycle followed by one beat with load_last; load_done 2 cycles after load_start.
- Reset mid-load: immediate return to IDLE; words already written are retained; no load_done pulse; load_overflow cleared.

## Configuration

- INSTR_MEM_PARITY_EN defined: each word stores INSTR_WIDTH+1 bits, with an even-parity bit computed at write. A fetch with mismatched parity asserts parity_err with instr_valid; instr_out still returns the stored data. Out-of-range fetches never assert parity_err.
- Not defined: no parity storage; parity_err is tied to 0.

## Test plan

- Reset, then load base=0 with beats 0x046, 0x056, 0x1D6 (last) → load_done pulses once; fetches 0,1,2 return 0x046, 0x056, 0x1D6 with instr_valid one cycle after each request.
- Back-to-back fetches of addr 2, 0, 1 on consecutive cycles → instr_valid high for 3 consecutive cycles with matching data; fetch_ready=0 during LOAD.
- ROM_SIZE=164, load base=162 with 4 beats → words land at 162, 163, 0, 1; load_overflow=1; fetch of 200 → instr_out=0, addr_err=1.
- load_start and fetch_req asserted in the same cycle → fetch not accepted (no instr_valid); FSM enters LOAD.
- reset_n pulsed low after 2 of 5 beats → outputs return to reset values; a refetch of the first 2 words returns the loaded data; no load_done.
- With INSTR_MEM_PARITY_EN, force-flip a stored bit via hierarchical access → the fetch returns parity_err=1; without the macro, parity_err stays 0.
